// File: rtl/mem_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 16;
  localparam int unsigned DEFAULT_DATA_W = 32;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 4;

  // Wide enough to hold MEM_LAT_MAX.
  localparam int unsigned CNT_W = 3;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_e;

  function automatic bit mem_lat_ok(int unsigned lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way requester pick; data wins ties unless MEM_ARB_RR_EN selects round-robin.
module mem_arb_pick
  import mem_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
`ifdef MEM_ARB_RR_EN
  input  owner_e last_win,
`endif
  output logic   pick_if,
  output logic   pick_d
);

  always_comb begin
    pick_if = 1'b0;
    pick_d  = 1'b0;
    if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      // Favour whoever lost the previous contended grant.
      if (last_win == OWN_D) begin
        pick_if = 1'b1;
      end else begin
        pick_d = 1'b1;
      end
`else
      pick_d = 1'b1;
`endif
    end else begin
      pick_if = if_req;
      pick_d  = d_req;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch and load/store requesters.
// Define MEM_ARB_RR_EN for round-robin arbitration on contention (default: data wins).
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

  if (!mem_lat_ok(MEM_LAT)) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be in 1..4");
  end

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  owner_e           owner_q;

  logic resp;
  logic port_free;
  logic pick_if;
  logic pick_d;
  logic read_gnt;

  // Response cycle doubles as a grant slot, giving one read per MEM_LAT cycles.
  assign resp      = (state_q == WAIT) && (cnt_q == LAT);
  assign port_free = (state_q == IDLE) || resp;

`ifdef MEM_ARB_RR_EN
  owner_e last_win_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_win_q <= OWN_D;
    end else if (port_free && if_req && d_req) begin
      last_win_q <= pick_d ? OWN_D : OWN_IF;
    end
  end
`endif

  mem_arb_pick u_pick (
    .if_req   (if_req),
    .d_req    (d_req),
`ifdef MEM_ARB_RR_EN
    .last_win (last_win_q),
`endif
    .pick_if  (pick_if),
    .pick_d   (pick_d)
  );

  assign if_gnt   = port_free & pick_if;
  assign d_gnt    = port_free & pick_d;
  assign mem_en   = if_gnt | d_gnt;
  assign mem_we   = d_gnt & d_we;
  assign read_gnt = if_gnt | (d_gnt & ~d_we);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= OWN_IF;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if (resp) begin
        if (owner_q == OWN_IF) begin
          if_rvalid <= 1'b1;
          if_rdata  <= mem_rdata;
        end else begin
          d_rvalid <= 1'b1;
          d_rdata  <= mem_rdata;
        end
      end
      if (read_gnt) begin
        state_q <= WAIT;
        cnt_q   <= CNT_W'(1);
        owner_q <= if_gnt ? OWN_IF : OWN_D;
      end else if (port_free) begin
        // Write granted, or nothing requested: the port goes idle.
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model (port busy-until time, response queue, shadow memory).
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic          b_if_req, b_if_gnt, b_if_rvalid;
  logic [AW-1:0] b_if_addr;
  logic [DW-1:0] b_if_rdata;
  logic          b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
  logic [AW-1:0] b_d_addr;
  logic [DW-1:0] b_d_wdata, b_d_rdata;
  logic          b_mem_en, b_mem_we;
  logic [AW-1:0] b_mem_addr;
  logic [DW-1:0] b_mem_wdata, b_mem_rdata;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
    .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  function automatic logic [DW-1:0] init_word(logic [AW-1:0] a);
    return {a ^ 16'h5a3c, ~a};
  endfunction

  // Memory macro models: latency 1 with writes, latency 3 read-only.
  logic [DW-1:0] env_mem [0:65535];
  bit            env_vld [0:65535];
  logic [DW-1:0] rd1;
  always @(posedge clk) begin
    if (mem_en && !mem_we) rd1 <= env_vld[mem_addr] ? env_mem[mem_addr] : init_word(mem_addr);
    else rd1 <= '0;
    if (mem_en && mem_we) begin
      env_mem[mem_addr] <= mem_wdata;
      env_vld[mem_addr] <= 1'b1;
    end
  end
  assign mem_rdata = rd1;

  logic [DW-1:0] p3 [0:2];
  always @(posedge clk) begin
    p3[0] <= (b_mem_en && !b_mem_we) ? init_word(b_mem_addr) : '0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign b_mem_rdata = p3[2];

  // Reference shadow memory, written only by the bench's own intent.
  logic [DW-1:0] ref_mem [0:65535];
  bit            ref_vld [0:65535];
  function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
    return ref_vld[a] ? ref_mem[a] : init_word(a);
  endfunction

  typedef struct {
    int            cyc;
    bit            is_if;
    logic [DW-1:0] data;
  } resp_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    b_if_req = 0; b_if_addr = '0; b_d_req = 0; b_d_we = 0; b_d_addr = '0; b_d_wdata = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    @(negedge clk);
    checks++;
    if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we} !== 6'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=000000",
               {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we});
    end
    checks++;
    if (if_rdata !== '0 || d_rdata !== '0) begin
      failures++;
      $display("FAIL reset_rdata got if=%h d=%h exp=0", if_rdata, d_rdata);
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || b_if_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mem got addr=%h wdata=%h b_rv=%b exp=0", mem_addr, mem_wdata,
               b_if_rvalid);
    end
    tick();
    rst_n = 1;
  endtask

  task automatic test_fetch_only();
    reset_dut();
    d_req = 1; d_we = 1; d_addr = 16'h0010; d_wdata = 32'h00500093;
    ref_mem[16'h0010] = 32'h00500093; ref_vld[16'h0010] = 1;
    tick();
    clear_inputs();
    tick();
    if_req = 1; if_addr = 16'h0010;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 ||
        mem_addr !== 16'h0010) begin
      failures++;
      $display("FAIL fetch_grant got gnt=%b en=%b we=%b addr=%h exp gnt=1 en=1 we=0 addr=0010",
               if_gnt, mem_en, mem_we, mem_addr);
    end
    tick();
    if_req = 0;
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b0 || mem_en !== 1'b0) begin
      failures++;
      $display("FAIL fetch_cycle1 got rvalid=%b en=%b exp=0 0", if_rvalid, mem_en);
    end
    tick();
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h00500093) begin
      failures++;
      $display("FAIL fetch_rvalid got rvalid=%b rdata=%h exp 1 00500093", if_rvalid, if_rdata);
    end
    tick();
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b0 || if_rdata !== 32'h00500093) begin
      failures++;
      $display("FAIL fetch_hold got rvalid=%b rdata=%h exp 0 00500093", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_contention();
    bit first_if;
    logic [DW-1:0] if_exp, d_exp;
`ifdef MEM_ARB_RR_EN
    first_if = 1;
`else
    first_if = 0;
`endif
    reset_dut();
    if_exp = ref_rd(16'h0004);
    d_exp  = ref_rd(16'h0100);
    if_req = 1; if_addr = 16'h0004; d_req = 1; d_we = 0; d_addr = 16'h0100;
    @(negedge clk);
    checks++;
    if (if_gnt !== first_if || d_gnt !== !first_if ||
        mem_addr !== (first_if ? 16'h0004 : 16'h0100)) begin
      failures++;
      $display("FAIL contend_first got if_gnt=%b d_gnt=%b addr=%h exp if_gnt=%b", if_gnt, d_gnt,
               mem_addr, first_if);
    end
    tick();
    if (first_if) if_req = 0; else d_req = 0;
    @(negedge clk);
    checks++;
    if (if_gnt !== !first_if || d_gnt !== first_if ||
        mem_addr !== (first_if ? 16'h0100 : 16'h0004)) begin
      failures++;
      $display("FAIL contend_second got if_gnt=%b d_gnt=%b addr=%h exp if_gnt=%b", if_gnt,
               d_gnt, mem_addr, !first_if);
    end
    tick();
    if_req = 0; d_req = 0;
    @(negedge clk);
    checks++;
    if (if_rvalid !== first_if || d_rvalid !== !first_if ||
        (first_if ? if_rdata : d_rdata) !== (first_if ? if_exp : d_exp)) begin
      failures++;
      $display("FAIL contend_resp1 got if_rv=%b d_rv=%b if_rd=%h d_rd=%h exp if_rv=%b", if_rvalid,
               d_rvalid, if_rdata, d_rdata, first_if);
    end
    tick();
    @(negedge clk);
    checks++;
    if (if_rvalid !== !first_if || d_rvalid !== first_if || if_rdata !== if_exp ||
        d_rdata !== d_exp) begin
      failures++;
      $display("FAIL contend_resp2 got if_rv=%b d_rv=%b if_rd=%h d_rd=%h exp %h %h", if_rvalid,
               d_rvalid, if_rdata, d_rdata, if_exp, d_exp);
    end
  endtask

  task automatic test_write_then_read();
    reset_dut();
    d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 32'hDEADBEEF;
    ref_mem[16'h0200] = 32'hDEADBEEF; ref_vld[16'h0200] = 1;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0200 ||
        mem_wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr_grant got gnt=%b en=%b we=%b addr=%h wdata=%h", d_gnt, mem_en, mem_we,
               mem_addr, mem_wdata);
    end
    tick();
    d_we = 0;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || mem_we !== 1'b0 || d_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rd_after_wr_grant got gnt=%b we=%b rvalid=%b exp 1 0 0", d_gnt, mem_we,
               d_rvalid);
    end
    tick();
    d_req = 0;
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rd_after_wr_early got rvalid=%b exp 0", d_rvalid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rd_after_wr_data got rvalid=%b rdata=%h exp 1 deadbeef", d_rvalid, d_rdata);
    end
  endtask

  task automatic test_back_to_back();
    bit e_gnt, e_rv;
    reset_dut();
    for (int c = 0; c < 9; c++) begin
      b_if_req  = (c <= 3);
      b_if_addr = (c == 0) ? 16'h0000 : 16'h0004;
      e_gnt = (c == 0) || (c == 3);
      e_rv  = (c == 4) || (c == 7);
      @(negedge clk);
      checks++;
      if (b_if_gnt !== e_gnt || b_mem_en !== e_gnt) begin
        failures++;
        $display("FAIL b2b_gnt c=%0d got gnt=%b en=%b exp %b", c, b_if_gnt, b_mem_en, e_gnt);
      end
      checks++;
      if (b_if_rvalid !== e_rv) begin
        failures++;
        $display("FAIL b2b_rvalid c=%0d got %b exp %b", c, b_if_rvalid, e_rv);
      end
      if (c == 3) begin
        checks++;
        if (b_mem_addr !== 16'h0004) begin
          failures++;
          $display("FAIL b2b_addr got %h exp 0004", b_mem_addr);
        end
      end
      if (c == 4 || c == 7) begin
        checks++;
        if (b_if_rdata !== init_word((c == 4) ? 16'h0000 : 16'h0004)) begin
          failures++;
          $display("FAIL b2b_rdata c=%0d got %h", c, b_if_rdata);
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_read();
    reset_dut();
    if_req = 1; if_addr = 16'h0010;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin
      failures++;
      $display("FAIL midrst_grant got %b exp 1", if_gnt);
    end
    tick();
    if_req = 0;
    rst_n  = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (if_rvalid !== 1'b0 || if_rdata !== '0 || mem_en !== 1'b0) begin
        failures++;
        $display("FAIL midrst_hold c=%0d got rv=%b rd=%h en=%b exp 0", c, if_rvalid, if_rdata,
                 mem_en);
      end
      tick();
    end
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
        failures++;
        $display("FAIL midrst_after c=%0d got if_rv=%b d_rv=%b exp 0", c, if_rvalid, d_rvalid);
      end
      tick();
    end
    d_req = 1; d_we = 0; d_addr = 16'h0020;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || mem_addr !== 16'h0020) begin
      failures++;
      $display("FAIL midrst_regrant got gnt=%b addr=%h exp 1 0020", d_gnt, mem_addr);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_rr();
    bit order [0:3];
    bit exp_ord [0:3];
    int n = 0;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_ord[i] = (i % 2 == 0);
`else
      exp_ord[i] = 1'b0;
`endif
      order[i] = 1'b0;
    end
    reset_dut();
    if_req = 1; if_addr = 16'h0008; d_req = 1; d_we = 0; d_addr = 16'h0108;
    for (int c = 0; c < 12 && n < 4; c++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin
        checks++;
        if (if_gnt && d_gnt) begin
          failures++;
          $display("FAIL rr_both_gnt c=%0d", c);
        end
        order[n] = if_gnt;
        n++;
      end
      tick();
    end
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL rr_grant_count got %0d exp 4", n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (order[i] !== exp_ord[i]) begin
        failures++;
        $display("FAIL rr_order i=%0d got if=%b exp if=%b", i, order[i], exp_ord[i]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_random();
    resp_t q[$];
    int next_free = 0;
    bit rr_last_d = 1;
    bit w_if, w_d, e_ifv, e_dv, free;
    logic [DW-1:0] exp_if_rd, exp_d_rd;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    reset_dut();
    exp_if_rd = '0;
    exp_d_rd  = '0;
    for (int c = 0; c < 500; c++) begin
      e_ifv = 0;
      e_dv  = 0;
      if (q.size() > 0 && q[0].cyc == c) begin
        if (q[0].is_if) begin e_ifv = 1; exp_if_rd = q[0].data; end
        else begin e_dv = 1; exp_d_rd = q[0].data; end
        void'(q.pop_front());
      end
      free = (c >= next_free);
      w_if = 0;
      w_d  = 0;
      if (free && if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
        if (rr_last_d) w_if = 1; else w_d = 1;
`else
        w_d = 1;
`endif
      end else if (free) begin
        w_if = if_req;
        w_d  = d_req;
      end
      e_addr  = w_d ? d_addr : (w_if ? if_addr : '0);
      e_wdata = w_d ? d_wdata : '0;
      @(negedge clk);
      checks++;
      if (if_gnt !== w_if || d_gnt !== w_d || mem_en !== (w_if | w_d) ||
          mem_we !== (w_d & d_we)) begin
        failures++;
        $display("FAIL rnd_gnt c=%0d got if=%b d=%b en=%b we=%b exp if=%b d=%b", c, if_gnt, d_gnt,
                 mem_en, mem_we, w_if, w_d);
      end
      checks++;
      if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin
        failures++;
        $display("FAIL rnd_mem c=%0d got addr=%h wdata=%h exp %h %h", c, mem_addr, mem_wdata,
                 e_addr, e_wdata);
      end
      checks++;
      if (if_rvalid !== e_ifv || d_rvalid !== e_dv || if_rdata !== exp_if_rd ||
          d_rdata !== exp_d_rd) begin
        failures++;
        $display("FAIL rnd_resp c=%0d got rv=%b%b rd=%h %h exp rv=%b%b rd=%h %h", c, if_rvalid,
                 d_rvalid, if_rdata, d_rdata, e_ifv, e_dv, exp_if_rd, exp_d_rd);
      end
      if (free && if_req && d_req) rr_last_d = w_d;
      if (w_if || (w_d && !d_we)) begin
        next_free = c + LAT;
        q.push_back('{cyc: c + LAT + 1, is_if: w_if, data: ref_rd(e_addr)});
      end else if (w_d) begin
        ref_mem[d_addr] = d_wdata;
        ref_vld[d_addr] = 1;
      end
      tick();
      if (w_if) if_req = 0;
      if (w_d) d_req = 0;
      if (!if_req && $urandom_range(0, 2) != 0) begin
        if_req  = 1;
        if_addr = AW'($urandom_range(0, 15) * 4);
      end
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req   = 1;
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = AW'($urandom_range(0, 15) * 4);
        d_wdata = $urandom;
      end
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_fetch_only();
    test_contention();
    test_write_then_read();
    test_back_to_back();
    test_reset_mid_read();
    test_rr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
